// File: rtl/spartan6_dsp48a1_pkg.sv
// Shared definitions for the DSP48A1-style slice: OPMODE field layout,
// X/Z multiplexer selects and the carry/B-source parameter encodings.
package spartan6_dsp48a1_pkg;

  localparam int unsigned A_W = 18;
  localparam int unsigned M_W = 36;
  localparam int unsigned P_W = 48;
  localparam int unsigned OPM_W = 8;

  // OPMODE bit positions
  localparam int unsigned OPM_X_LSB   = 0;
  localparam int unsigned OPM_X_MSB   = 1;
  localparam int unsigned OPM_Z_LSB   = 2;
  localparam int unsigned OPM_Z_MSB   = 3;
  localparam int unsigned OPM_PREUSE  = 4;
  localparam int unsigned OPM_CARRY   = 5;
  localparam int unsigned OPM_PRESUB  = 6;
  localparam int unsigned OPM_POSTSUB = 7;

  localparam int unsigned CARRYINSEL_PORT    = 0;
  localparam int unsigned CARRYINSEL_OPMODE5 = 1;
  localparam int unsigned B_INPUT_DIRECT     = 0;
  localparam int unsigned B_INPUT_CASCADE    = 1;

  typedef enum logic [1:0] {
    X_ZERO   = 2'd0,
    X_M      = 2'd1,
    X_P      = 2'd2,
    X_CONCAT = 2'd3
  } xmux_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } zmux_e;

endpackage

// File: rtl/spartan6_dsp48a1_reg_stage.sv
// Optional pipeline register: synchronous active-low reset with priority over
// clock enable, or a plain wire when REG is 0.
module dsp_reg_stage #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned REG   = 1
) (
  input  logic             CLK,
  input  logic             CE,
  input  logic             RST,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (REG != 0) begin : g_reg
      logic [WIDTH-1:0] data_q;

      always_ff @(posedge CLK) begin
        if (!RST) begin
          data_q <= '0;
        end else if (CE) begin
          data_q <= d_i;
        end
      end

      assign q_o = data_q;
    end else begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{CLK, CE, RST};
      assign q_o = d_i;
    end
  endgenerate

endmodule

// File: rtl/spartan6_dsp48a1.sv
// DSP48A1-style slice: pre-adder, 18x18 unsigned multiplier and 48-bit
// post-adder/subtractor, each pipeline stage individually optional.
module spartan6_dsp48a1
  import spartan6_dsp48a1_pkg::*;
#(
  parameter int unsigned A0REG       = 1,
  parameter int unsigned A1REG       = 1,
  parameter int unsigned B0REG       = 1,
  parameter int unsigned B1REG       = 1,
  parameter int unsigned CREG        = 1,
  parameter int unsigned DREG        = 1,
  parameter int unsigned MREG        = 1,
  parameter int unsigned PREG        = 1,
  parameter int unsigned CARRYINREG  = 1,
  parameter int unsigned CARRYOUTREG = 1,
  parameter int unsigned OPMODEREG   = 1,
  parameter int unsigned CARRYINSEL  = 1,
  parameter int unsigned B_INPUT     = 0
) (
  input  logic        CLK,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTCARRYIN,
  input  logic        RSTOPMODE,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CECARRYIN,
  input  logic        CEOPMODE,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] BCIN,
  input  logic [17:0] D,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic        CARRYIN,
  input  logic [7:0]  OPMODE,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic [17:0] BCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  logic [OPM_W-1:0] opm_q;
  logic [A_W-1:0]   a0_q, a1_q, b0_q, b1_q, d_q;
  logic [A_W-1:0]   b_src, preadd, b1_d;
  logic [P_W-1:0]   c_q, p_q, x_mux, z_mux;
  logic [M_W-1:0]   mult, m_q;
  logic             cin_d, cin_q, co_q;
  logic [P_W:0]     post;
  xmux_e            x_sel;
  zmux_e            z_sel;

  dsp_reg_stage #(.WIDTH(OPM_W), .REG(OPMODEREG)) u_opmode (
    .CLK(CLK), .CE(CEOPMODE), .RST(RSTOPMODE), .d_i(OPMODE), .q_o(opm_q)
  );

  dsp_reg_stage #(.WIDTH(A_W), .REG(A0REG)) u_a0 (
    .CLK(CLK), .CE(CEA), .RST(RSTA), .d_i(A), .q_o(a0_q)
  );

  dsp_reg_stage #(.WIDTH(A_W), .REG(A1REG)) u_a1 (
    .CLK(CLK), .CE(CEA), .RST(RSTA), .d_i(a0_q), .q_o(a1_q)
  );

  assign b_src = (B_INPUT == B_INPUT_CASCADE) ? BCIN : B;

  dsp_reg_stage #(.WIDTH(A_W), .REG(B0REG)) u_b0 (
    .CLK(CLK), .CE(CEB), .RST(RSTB), .d_i(b_src), .q_o(b0_q)
  );

  dsp_reg_stage #(.WIDTH(A_W), .REG(DREG)) u_d (
    .CLK(CLK), .CE(CED), .RST(RSTD), .d_i(D), .q_o(d_q)
  );

  always_comb begin
    preadd = opm_q[OPM_PRESUB] ? (d_q - b0_q) : (d_q + b0_q);
    b1_d   = opm_q[OPM_PREUSE] ? preadd : b0_q;
  end

  dsp_reg_stage #(.WIDTH(A_W), .REG(B1REG)) u_b1 (
    .CLK(CLK), .CE(CEB), .RST(RSTB), .d_i(b1_d), .q_o(b1_q)
  );

  assign mult = {18'd0, a1_q} * {18'd0, b1_q};

  dsp_reg_stage #(.WIDTH(M_W), .REG(MREG)) u_m (
    .CLK(CLK), .CE(CEM), .RST(RSTM), .d_i(mult), .q_o(m_q)
  );

  dsp_reg_stage #(.WIDTH(P_W), .REG(CREG)) u_c (
    .CLK(CLK), .CE(CEC), .RST(RSTC), .d_i(C), .q_o(c_q)
  );

  assign cin_d = (CARRYINSEL == CARRYINSEL_OPMODE5) ? opm_q[OPM_CARRY] : CARRYIN;

  dsp_reg_stage #(.WIDTH(1), .REG(CARRYINREG)) u_cin (
    .CLK(CLK), .CE(CECARRYIN), .RST(RSTCARRYIN), .d_i(cin_d), .q_o(cin_q)
  );

  assign x_sel = xmux_e'(opm_q[OPM_X_MSB:OPM_X_LSB]);
  assign z_sel = zmux_e'(opm_q[OPM_Z_MSB:OPM_Z_LSB]);

  always_comb begin
    x_mux = '0;
    unique case (x_sel)
      X_ZERO:   x_mux = '0;
      X_M:      x_mux = {12'd0, m_q};
      X_P:      x_mux = p_q;
      X_CONCAT: x_mux = {d_q[11:0], a1_q, b1_q};
      default:  x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    unique case (z_sel)
      Z_ZERO:  z_mux = '0;
      Z_PCIN:  z_mux = PCIN;
      Z_P:     z_mux = p_q;
      Z_C:     z_mux = c_q;
      default: z_mux = '0;
    endcase
  end

  // Bit 48 acts as carry on add and as borrow (wrapped sign) on subtract.
  always_comb begin
    if (opm_q[OPM_POSTSUB]) begin
      post = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin_q});
    end else begin
      post = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin_q};
    end
  end

  dsp_reg_stage #(.WIDTH(P_W), .REG(PREG)) u_p (
    .CLK(CLK), .CE(CEP), .RST(RSTP), .d_i(post[P_W-1:0]), .q_o(p_q)
  );

  dsp_reg_stage #(.WIDTH(1), .REG(CARRYOUTREG)) u_cout (
    .CLK(CLK), .CE(CECARRYIN), .RST(RSTCARRYIN), .d_i(post[P_W]), .q_o(co_q)
  );

  assign M         = m_q;
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign BCOUT     = b1_q;
  assign CARRYOUT  = co_q;
  assign CARRYOUTF = co_q;

endmodule

// File: tb/tb_spartan6_dsp48a1.sv
// Directed-vector bench: stimulus pushes expected outputs into a queue and a
// monitor process pops and compares them on the falling edge.
module tb_spartan6_dsp48a1;

  logic        clk;
  logic        rsta, rstb, rstc, rstd, rstm, rstp, rstcin, rstopm;
  logic        cea, ceb, cec, ced, cem, cep, cecin, ceopm;
  logic [17:0] a, b, bcin, d;
  logic [47:0] c, pcin;
  logic        carryin;
  logic [7:0]  opmode;

  logic [35:0] m0, m1;
  logic [47:0] p0, p1, pc0, pc1;
  logic [17:0] bc0, bc1;
  logic        co0, co1, cof0, cof1;

  spartan6_dsp48a1 u_dut0 (
    .CLK(clk), .RSTA(rsta), .RSTB(rstb), .RSTC(rstc), .RSTD(rstd), .RSTM(rstm),
    .RSTP(rstp), .RSTCARRYIN(rstcin), .RSTOPMODE(rstopm),
    .CEA(cea), .CEB(ceb), .CEC(cec), .CED(ced), .CEM(cem), .CEP(cep),
    .CECARRYIN(cecin), .CEOPMODE(ceopm),
    .A(a), .B(b), .BCIN(bcin), .D(d), .C(c), .PCIN(pcin), .CARRYIN(carryin),
    .OPMODE(opmode), .M(m0), .P(p0), .PCOUT(pc0), .BCOUT(bc0),
    .CARRYOUT(co0), .CARRYOUTF(cof0)
  );

  spartan6_dsp48a1 #(.B_INPUT(1)) u_dut1 (
    .CLK(clk), .RSTA(rsta), .RSTB(rstb), .RSTC(rstc), .RSTD(rstd), .RSTM(rstm),
    .RSTP(rstp), .RSTCARRYIN(rstcin), .RSTOPMODE(rstopm),
    .CEA(cea), .CEB(ceb), .CEC(cec), .CED(ced), .CEM(cem), .CEP(cep),
    .CECARRYIN(cecin), .CEOPMODE(ceopm),
    .A(a), .B(b), .BCIN(bcin), .D(d), .C(c), .PCIN(pcin), .CARRYIN(carryin),
    .OPMODE(opmode), .M(m1), .P(p1), .PCOUT(pc1), .BCOUT(bc1),
    .CARRYOUT(co1), .CARRYOUTF(cof1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned dut;
    logic [47:0] p;
    logic [35:0] m;
    logic [17:0] bc;
    logic        co;
    bit          chk_m;
    bit          chk_bc;
    bit          chk_co;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic cmp(input string nm, input logic [47:0] act, input logic [47:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: each check request is serviced at the next falling edge.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          cmp({e.name, ".P"}, p0, e.p);
          cmp({e.name, ".PCOUT"}, pc0, e.p);
          if (e.chk_m)  cmp({e.name, ".M"}, {12'd0, m0}, {12'd0, e.m});
          if (e.chk_bc) cmp({e.name, ".BCOUT"}, {30'd0, bc0}, {30'd0, e.bc});
          if (e.chk_co) begin
            cmp({e.name, ".CARRYOUT"}, {47'd0, co0}, {47'd0, e.co});
            cmp({e.name, ".CARRYOUTF"}, {47'd0, cof0}, {47'd0, e.co});
          end
        end else begin
          cmp({e.name, ".P"}, p1, e.p);
          cmp({e.name, ".PCOUT"}, pc1, e.p);
          if (e.chk_m)  cmp({e.name, ".M"}, {12'd0, m1}, {12'd0, e.m});
          if (e.chk_bc) cmp({e.name, ".BCOUT"}, {30'd0, bc1}, {30'd0, e.bc});
          if (e.chk_co) begin
            cmp({e.name, ".CARRYOUT"}, {47'd0, co1}, {47'd0, e.co});
            cmp({e.name, ".CARRYOUTF"}, {47'd0, cof1}, {47'd0, e.co});
          end
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_full(input string nm, input int unsigned dut,
                             input logic [47:0] p, input logic [35:0] m,
                             input logic [17:0] bc, input logic co);
    exp_t e;
    e.name = nm; e.dut = dut; e.p = p; e.m = m; e.bc = bc; e.co = co;
    e.chk_m = 1'b1; e.chk_bc = 1'b1; e.chk_co = 1'b1;
    exp_q.push_back(e);
    -> chk_ev;
  endtask

  task automatic expect_p(input string nm, input logic [47:0] p);
    exp_t e;
    e.name = nm; e.dut = 0; e.p = p; e.m = '0; e.bc = '0; e.co = 1'b0;
    e.chk_m = 1'b0; e.chk_bc = 1'b0; e.chk_co = 1'b0;
    exp_q.push_back(e);
    -> chk_ev;
  endtask

  task automatic set_rst(input logic v);
    rsta = v; rstb = v; rstc = v; rstd = v; rstm = v; rstp = v; rstcin = v; rstopm = v;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    set_rst(1'b0);
    cea = 1; ceb = 1; cec = 1; ced = 1; cem = 1; cep = 1; cecin = 1; ceopm = 1;
    a = 18'd2; b = 18'd3; bcin = 18'd0; d = 18'd4; c = 48'd5; pcin = '0;
    carryin = 1'b0; opmode = 8'h1D;
    step(3);
    expect_full("reset", 0, 48'd0, 36'd0, 18'd0, 1'b0);
    step(1);
    set_rst(1'b1);

    // Pre-adder add: B1 = 4+3 = 7, M = 14, P = 5 + 14
    step(5);
    expect_full("op1D", 0, 48'd19, 36'd14, 18'd7, 1'b0);

    // C reaches P two edges after it changes
    c = 48'd10;
    step(1);
    expect_p("c_lat1", 48'd19);
    step(1);
    expect_p("c_lat2", 48'd24);
    c = 48'd5;

    // Pre-adder subtract: B1 = 1, M = 2, P = 7
    opmode = 8'h5D;
    step(5);
    expect_full("op5D", 0, 48'd7, 36'd2, 18'd1, 1'b0);

    // Carry-in from OPMODE[5]
    opmode = 8'h3D;
    step(5);
    expect_full("op3D", 0, 48'd20, 36'd14, 18'd7, 1'b0);

    // Post-subtract: 5 - 14 wraps, borrow shows on CARRYOUT
    opmode = 8'h9D;
    step(5);
    expect_full("op9D", 0, 48'hFFFF_FFFF_FFF7, 36'd14, 18'd7, 1'b1);

    // Concatenated X path
    opmode = 8'h03;
    step(5);
    expect_full("op03", 0, (48'd4 << 36) | (48'd2 << 18) | 48'd3, 36'd6, 18'd3, 1'b0);

    // Accumulate P += M, then clock-enable hold and single-stage reset
    opmode = 8'h01;
    step(5);
    expect_p("acc_seed", 48'd6);
    opmode = 8'h09;
    step(1); expect_p("acc_e1", 48'd6);
    step(1); expect_p("acc_e2", 48'd12);
    step(1); expect_p("acc_e3", 48'd18);
    step(1); expect_p("acc_e4", 48'd24);
    cep = 1'b0;
    step(1); expect_p("hold1", 48'd24);
    step(1); expect_p("hold2", 48'd24);
    cep = 1'b1; rstp = 1'b0;
    step(1); expect_p("rstp", 48'd0);
    rstp = 1'b1;
    step(1); expect_p("refill1", 48'd6);
    step(1); expect_p("refill2", 48'd12);

    // B source select: cascade instance takes BCIN, direct instance takes B
    bcin = 18'd5; b = 18'd3; a = 18'd1; opmode = 8'h01;
    step(5);
    expect_full("bcin_casc", 1, 48'd5, 36'd5, 18'd5, 1'b0);
    expect_full("bcin_direct", 0, 48'd3, 36'd3, 18'd3, 1'b0);

    step(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
